// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: state encoding,
// default framing parameters and the idle line level.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned DefaultClksPerBit = 4;
  localparam int unsigned DefaultDataBits   = 8;
  localparam logic        LineIdle          = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q;

  assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises a captured word as start bit, DATA_BITS data
// bits LSB first and one stop bit, then pulses done_tx for one cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned DATA_BITS    = DefaultDataBits
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 done_tx
);

  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [IdxW-1:0]      bit_idx_q;
  logic                 serial_out_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 bit_end;
  logic                 baud_clear;

  // Later state entries coincide with the counter wrapping, so holding it
  // clear in idle is enough to start every bit period from zero.
  assign baud_clear = (state_q == StIdle);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      serial_out_q <= LineIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          serial_out_q <= LineIdle;
          busy_q       <= 1'b0;
          bit_idx_q    <= '0;
          if (start) begin
            shreg_q      <= data_in;
            serial_out_q <= ~LineIdle;
            busy_q       <= 1'b1;
            state_q      <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q      <= StData;
            bit_idx_q    <= '0;
            serial_out_q <= shreg_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + IdxW'(1);
            if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
              state_q      <= StStop;
              serial_out_q <= LineIdle;
            end else begin
              // Drive the next bit directly so the line changes on the bit boundary.
              serial_out_q <= shreg_q[1];
            end
          end
        end
        StStop: begin
          if (bit_end) begin
            state_q      <= StIdle;
            serial_out_q <= LineIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        default: begin
          state_q      <= StIdle;
          serial_out_q <= LineIdle;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign done_tx    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a behavioural loopback receiver.
module tb_uart_tx;

  localparam int unsigned Cpb = 4;
  localparam int unsigned Db  = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [Db-1:0] data_in;
  logic          serial_out;
  logic          busy;
  logic          done_tx;

  int total = 0;
  int bad   = 0;

  uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (Db)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .serial_out(serial_out),
    .busy      (busy),
    .done_tx   (done_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: rx_cnt is the cycle offset from the first low line cycle;
  // each bit is sampled mid-slot.
  logic       rx_active;
  int         rx_cnt;
  logic [7:0] rx_sh;
  int         rx_count;
  int         rx_ferr;
  logic [7:0] rx_bytes [0:15];

  initial begin
    rx_count = 0;
    rx_ferr  = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
    end else if (!rx_active) begin
      if (serial_out == 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= Cpb + Cpb / 2 && ((rx_cnt - Cpb / 2) % Cpb) == 0) begin
        if (rx_cnt < 9 * Cpb) begin
          rx_sh <= {serial_out, rx_sh[7:1]};
        end else begin
          if (serial_out == 1'b1) begin
            rx_bytes[rx_count % 16] <= rx_sh;
            rx_count <= rx_count + 1;
          end else begin
            rx_ferr <= rx_ferr + 1;
          end
          rx_active <= 1'b0;
        end
      end
    end
  end

  // Expected {serial_out, busy, done_tx} in cycle c of a frame started in cycle 0.
  function automatic logic [2:0] exp_out(input int c, input logic [7:0] d);
    if (c >= 1 && c <= 4) return 3'b010;
    if (c >= 5 && c <= 36) return {d[(c - 5) / 4], 2'b10};
    if (c >= 37 && c <= 40) return 3'b110;
    if (c == 41) return 3'b101;
    return 3'b100;
  endfunction

  // Called at the negedge of cycle 0; returns at the negedge of cycle 41.
  task automatic send_and_check(input logic [7:0] d, input bit glitch, input string name);
    logic [2:0] got;
    logic [2:0] exp;
    start   = 1'b1;
    data_in = d;
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start   = 1'b0;
        data_in = ~d;
      end
      if (glitch && c == 12) begin
        start   = 1'b1;
        data_in = 8'hFF;
      end
      if (glitch && c == 13) start = 1'b0;
      got = {serial_out, busy, done_tx};
      exp = exp_out(c, d);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d {line,busy,done}: got %b want %b", name, c, got, exp);
      end
    end
  endtask

  task automatic check_idle(input int cycles, input string name);
    logic [2:0] got;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      got = {serial_out, busy, done_tx};
      total++;
      if (got !== 3'b100) begin
        bad++;
        $display("FAIL %s idle cycle %0d {line,busy,done}: got %b want 100", name, c, got);
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    @(negedge clk);
    check_idle(2, "reset_held");
    reset = 1'b0;
    check_idle(20, "after_reset");
  endtask

  task automatic test_frame_a5();
    send_and_check(8'hA5, 1'b0, "frame_a5");
    check_idle(5, "frame_a5_tail");
  endtask

  task automatic test_start_while_busy();
    send_and_check(8'hA5, 1'b1, "busy_start");
    check_idle(50, "busy_start_no_second");
  endtask

  task automatic test_back_to_back();
    int base;
    base = rx_count;
    send_and_check(8'hA5, 1'b0, "b2b_first");
    send_and_check(8'h00, 1'b0, "b2b_second");
    check_idle(3, "b2b_tail");
    total++;
    if (rx_count - base !== 2) begin
      bad++;
      $display("FAIL b2b_rx_count: got %0d want 2", rx_count - base);
    end
  endtask

  task automatic test_reset_abort();
    logic [2:0] got;
    int base;
    base    = rx_count;
    start   = 1'b1;
    data_in = 8'h3C;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      got = {serial_out, busy, done_tx};
      total++;
      if (got !== exp_out(c, 8'h3C)) begin
        bad++;
        $display("FAIL abort_pre cycle %0d: got %b want %b", c, got, exp_out(c, 8'h3C));
      end
      if (c == 10) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    got   = {serial_out, busy, done_tx};
    total++;
    if (got !== 3'b100) begin
      bad++;
      $display("FAIL abort_cycle11: got %b want 100", got);
    end
    check_idle(4, "abort_gap");
    send_and_check(8'h3C, 1'b0, "abort_restart");
    check_idle(3, "abort_tail");
    total++;
    if (rx_count - base !== 1 || rx_bytes[base % 16] !== 8'h3C) begin
      bad++;
      $display("FAIL abort_rx: got count %0d byte %h want count 1 byte 3c",
               rx_count - base, rx_bytes[base % 16]);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] vec [0:3];
    int base;
    int ferr0;
    vec[0] = 8'h00;
    vec[1] = 8'hFF;
    vec[2] = 8'h55;
    vec[3] = 8'h81;
    base   = rx_count;
    ferr0  = rx_ferr;
    for (int i = 0; i < 4; i++) begin
      send_and_check(vec[i], 1'b0, "loopback_line");
      total++;
      if (rx_count - base !== i + 1) begin
        bad++;
        $display("FAIL loopback_done_count frame %0d: got %0d want %0d", i, rx_count - base, i + 1);
      end
    end
    check_idle(5, "loopback_tail");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_bytes[(base + i) % 16] !== vec[i]) begin
        bad++;
        $display("FAIL loopback_byte %0d: got %h want %h", i, rx_bytes[(base + i) % 16], vec[i]);
      end
    end
    total++;
    if (rx_ferr !== ferr0) begin
      bad++;
      $display("FAIL loopback_framing: got %0d errors want 0", rx_ferr - ferr0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame_a5();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit path, the outbound partner of the team's UART receive controller.
- Accepts a parallel byte on a single-cycle start request and serialises it as an 8N1-style frame: 1 start bit (low), DATA_BITS data bits LSB first, 1 stop bit (high).
- Each bit is held for CLKS_PER_BIT clock cycles.
- Reports completion with a one-cycle done pulse, symmetrical to the receiver's done signal.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  transmit request, sampled only in IDLE.
- data_in  input  DATA_BITS  byte to send; captured on the accepting cycle.
- serial_out  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.
- done_tx  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (synchronous, active-high): serial_out=1, busy=0, done_tx=0, state=IDLE, baud counter=0, bit index=0. Reset asserted mid-frame aborts the frame:
  - serial_out=1 on the next cycle.
  - No done_tx pulse.
- All outputs are registered.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - serial_out=1, busy=0.
  - If start=1, capture data_in into the shift register, clear the baud counter, and go to START.
- START:
  - serial_out=0, busy=1.
  - After CLKS_PER_BIT cycles, go to DATA with bit index 0.
- DATA:
  - serial_out = shift register bit 0, busy=1.
  - At each bit end, shift right and increment the bit index.
  - After DATA_BITS bits, go to STOP.
- STOP:
  - serial_out=1, busy=1.
  - After CLKS_PER_BIT cycles, go to IDLE and assert done_tx for exactly that first IDLE cycle.
- Latency: with start high in cycle N, the start bit occupies cycles N+1..N+CLKS_PER_BIT.
  - Frame occupies (DATA_BITS+2)*CLKS_PER_BIT cycles.
  - done_tx fires in cycle N+(DATA_BITS+2)*CLKS_PER_BIT+1.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and generates an internal bit_end.
  - Cleared on every state entry.
- Bit index width: $clog2(DATA_BITS+1).
- start while busy=1: ignored. It is not queued, and the frame in flight is unaffected.
- data_in changes while busy=1: ignored, because the shift register holds the captured copy.
- start in the same cycle as done_tx (IDLE): accepted; back-to-back frames have zero idle gap beyond that one cycle.
- start held high continuously: frames are sent back-to-back, each capturing data_in in its accepting IDLE cycle.
- Unreachable state encodings recover to IDLE with serial_out=1.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (IDLE/START/DATA/STOP), shared with the receive side;
  - default CLKS_PER_BIT and DATA_BITS;
  - the line idle level constant (1).
- Sub-module uart_baud_gen provides the baud counter and bit_end tick. It is parameterised by CLKS_PER_BIT and has a synchronous clear input. The receive path can reuse it.
- The FSM, shift register and bit index stay in uart_tx.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8):
- Reset held 3 cycles, then idle 20 cycles -> serial_out=1, busy=0, done_tx=0 throughout.
- start=1 with data_in=0xA5 in cycle 0 ->
  - serial_out=0 in cycles 1-4;
  - bits 1,0,1,0,0,1,0,1 in 4-cycle slots over cycles 5-36;
  - serial_out=1 in cycles 37-40;
  - busy=1 in cycles 1-40;
  - done_tx=1 only in cycle 41.
- During the 0xA5 frame, pulse start with data_in=0xFF at cycle 12 -> line waveform identical to the previous case, and no second frame.
- start=1 with data_in=0x00 in cycle 41 (coincident with done_tx) -> start bit in cycles 42-45, then 32 low data cycles, stop in cycles 78-81, done_tx in cycle 82.
- reset=1 in cycle 10 of a 0x3C frame -> cycle 11: serial_out=1, busy=0; no done_tx; a new start at cycle 15 produces a clean full frame.
- Loopback into the team's UART receive controller, sending 0x00, 0xFF, 0x55, 0x81 -> receiver reports all four bytes correctly, one receiver done per frame.
